gate_eval_sched: RTL and testbench
==================================

Name: gate_eval_sched

Overview:
- Round-robin scheduler that shares one conditional-AND evaluation unit among NREQ requesters.
- Evaluation function: f = a ? (c & b) : c, applied bitwise over W bits.
- Each requester presents an operand set and raises req. The scheduler grants one requester, captures its operands and evaluates them.
- It returns the result tagged with the requester id over a valid/ready handshake. It sits between the requester pool and the single shared evaluation datapath.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 8, operand/result width in bits.
- IDW, 2, id width; must equal clog2(NREQ), minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; held high until the matching gnt bit.
- op_a  input  NREQ  per-requester mode bit a; requester i uses op_a[i].
- op_b  input  NREQ*W  per-requester operand b; requester i uses bits [i*W +: W].
- op_c  input  NREQ*W  per-requester operand c; same slicing as op_b.
- gnt  output  NREQ  one-hot grant, one-cycle pulse.
- busy  output  1  high whenever state != IDLE.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts the result.
- res_id  output  IDW  index of the granted requester.
- res_data  output  W  evaluated result.
- stat_grants  output  16  grant counter (see Optional Feature).

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, gnt = 0, busy = 0, res_valid = 0.
  - res_id = 0, res_data = 0, stat_grants = 0.
  - Round-robin pointer rr_ptr = 0.
- Reset asserted mid-operation aborts the transaction and discards any pending result. No gnt and no res_valid are produced in the cycle after reset.
- FSM states: IDLE, GRANT, EVAL, RESP.
- IDLE:
  - If any req bit is high, select the winner: the first set bit searching from rr_ptr upward, wrapping NREQ-1 -> 0.
  - Register the winner index into res_id and go to GRANT.
  - If req == 0, stay in IDLE.
- GRANT (1 cycle):
  - gnt[res_id] = 1.
  - Capture op_a, op_b and op_c of the winner into internal registers.
  - rr_ptr <= (res_id + 1) mod NREQ.
  - Go to EVAL.
- EVAL (1 cycle):
  - res_data <= a_q ? (c_q & b_q) : c_q.
  - res_valid <= 1; go to RESP.
- RESP:
  - Hold res_valid, res_id and res_data stable until res_ready is high.
  - On the res_valid & res_ready cycle: res_valid <= 0 and go to IDLE.
  - New requests are not arbitrated while in RESP (no bypass).
- Latency: req seen in IDLE at cycle T gives gnt at T+1 and res_valid at T+3 (earliest). Maximum throughput is one transaction per 4 cycles when res_ready is held high.
- A requester that drops req before its gnt is simply not selected. The winner is fixed at the IDLE decision; the captured operands are those present in the GRANT cycle.
- Simultaneous requests: strict round-robin. A requester granted last has the lowest priority on the next decision. No starvation: any held req is granted within NREQ transactions.
- rr_ptr wraps from NREQ-1 to 0.
- res_id values >= NREQ cannot occur.
- busy = (state != IDLE), combinational from the state register.

Optional Feature:
- Macro: GATE_SCHED_STATS_EN.
- Defined: stat_grants increments by 1 on every GRANT-state cycle and saturates at 16'hFFFF (no wrap). It is cleared by rst.
- Undefined: no counter logic; stat_grants is tied to 16'h0000. The port list is unchanged.

Test Plan:
- Reset, then req = 4'b0000 for 10 cycles -> gnt = 0, busy = 0, res_valid = 0 throughout, stat_grants = 0.
- Single request: req = 4'b0100, op_a[2] = 1, op_b slice = 8'hF0, op_c slice = 8'h3C, res_ready = 1 -> gnt = 4'b0100 at T+1; res_valid at T+3 with res_id = 2, res_data = 8'h30.
- Mode-0 passthrough: req[1] with op_a[1] = 0, b = 8'h00, c = 8'hA5 -> res_data = 8'hA5, res_id = 1.
- Fairness: req = 4'b1111 held, res_ready = 1 -> grant order 0, 1, 2, 3, 0; each gnt one-hot, 4 cycles apart. With GATE_SCHED_STATS_EN, stat_grants = 5.
- Backpressure: res_ready = 0 for 6 cycles after res_valid -> res_valid, res_id and res_data held stable and no new gnt. Raising res_ready gives res_valid low next cycle, then arbitration resumes.
- Reset mid-operation: assert rst during EVAL -> next cycle state IDLE, res_valid = 0, and no result is delivered for the aborted request. rr_ptr = 0, so req = 4'b1010 then grants requester 1 first.

Source files
------------

// File: rtl/gate_eval_sched.sv
// Round-robin scheduler sharing one conditional-AND unit (f = a ? (c & b) : c) among NREQ requesters.
// Optional grant statistics counter enabled by defining GATE_SCHED_STATS_EN.
module gate_eval_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   op_a,
  input  logic [NREQ*W-1:0] op_b,
  input  logic [NREQ*W-1:0] op_c,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_data,
  output logic [15:0]       stat_grants
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EVAL  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_X  = (IDW + 1)'(NREQ);

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win_idx;
  logic             win_found;
  logic [IDW:0]     scan;

  logic [W-1:0]     b_arr [NREQ];
  logic [W-1:0]     c_arr [NREQ];

  logic             a_p1;
  logic [W-1:0]     b_p1;
  logic [W-1:0]     c_p1;

  function automatic logic [W-1:0] eval_gate(input logic a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] c);
    return a ? (c & b) : c;
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign b_arr[i] = op_b[i*W +: W];
    assign c_arr[i] = op_c[i*W +: W];
  end

  // Search req starting at rr_ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = {1'b0, rr_ptr} + (IDW + 1)'(i);
      if (scan >= NREQ_X) begin
        scan = scan - NREQ_X;
      end
      if (!win_found && req[scan[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = GRANT;
      GRANT:   state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state == GRANT) begin
      gnt[res_id] = 1'b1;
    end
    busy = (state != IDLE);
  end

  // Stage p0 -> p1: winner operands captured during the GRANT cycle.
  always_ff @(posedge clk) begin
    if (state == GRANT) begin
      a_p1 <= op_a[res_id];
      b_p1 <= b_arr[res_id];
      c_p1 <= c_arr[res_id];
    end
  end

  // Stage p1 -> result: evaluated in EVAL, held through RESP until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      res_id    <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) res_id <= win_idx;
        end
        GRANT: begin
          rr_ptr <= next_ptr(res_id);
        end
        EVAL: begin
          res_data  <= eval_gate(a_p1, b_p1, c_p1);
          res_valid <= 1'b1;
        end
        RESP: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_SCHED_STATS_EN
  logic [15:0] grant_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (state == GRANT) begin
      grant_cnt <= sat_inc(grant_cnt);
    end
  end

  assign stat_grants = grant_cnt;
`else
  assign stat_grants = 16'h0000;
`endif

endmodule

// File: tb/tb_gate_eval_sched.sv
// Self-checking bench for gate_eval_sched: directed scenarios plus randomized transactions vs. a reference model.
module tb_gate_eval_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   op_a = '0;
  logic [NREQ*W-1:0] op_b = '0;
  logic [NREQ*W-1:0] op_c = '0;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_data;
  logic [15:0]       stat_grants;

  int checks = 0;
  int passes = 0;
  int m_ptr = 0;
  int n_grants = 0;

  gate_eval_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data), .stat_grants(stat_grants)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] ref_eval(input logic a, input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = a ? (b[k] & c[k]) : c[k];
    return r;
  endfunction

  function automatic logic [15:0] exp_stats();
`ifdef GATE_SCHED_STATS_EN
    return (n_grants > 65535) ? 16'hFFFF : 16'(n_grants);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic apply_reset();
    rst = 1'b1; req = '0; res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    m_ptr = 0; n_grants = 0;
  endtask

  task automatic wait_grant(input int maxc, output logic [NREQ-1:0] g, output int n);
    g = '0;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      if (gnt != '0) begin g = gnt; n = c; return; end
    end
    n = -1;
  endtask

  task automatic drain();
    res_ready = 1'b1; req = '0;
    for (int c = 0; c < 10 && busy; c++) tick();
    checks++;
    if (busy !== 1'b0) $display("FAIL drain_timeout busy=%b required 0", busy);
    else passes++;
  endtask

  task automatic set_op(input int i, input logic a, input logic [W-1:0] b, input logic [W-1:0] c);
    op_a[i] = a; op_b[i*W +: W] = b; op_c[i*W +: W] = c;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({gnt, busy, res_valid} !== '0) $display("FAIL reset_idle cyc=%0d gnt=%b busy=%b vld=%b required 0", c, gnt, busy, res_valid);
      else passes++;
      tick();
    end
    checks++;
    if ({res_id, res_data, stat_grants} !== '0) $display("FAIL reset_regs id=%0d data=%h stats=%0d required 0", res_id, res_data, stat_grants);
    else passes++;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g; int n;
    apply_reset();
    set_op(2, 1'b1, 8'hF0, 8'h3C);
    res_ready = 1'b1; req = 4'b0100;
    wait_grant(6, g, n); n_grants++;
    checks++;
    if (n !== 1 || g !== 4'b0100) $display("FAIL single_gnt lat=%0d gnt=%b required 1 0100", n, g);
    else passes++;
    tick(); req = '0;
    checks++;
    if (res_valid !== 1'b0) $display("FAIL single_early_vld vld=%b required 0", res_valid);
    else passes++;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== 8'h30)
      $display("FAIL single_result vld=%b id=%0d data=%h required 1 2 30", res_valid, res_id, res_data);
    else passes++;
    tick();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_done vld=%b busy=%b required 0 0", res_valid, busy);
    else passes++;
  endtask

  task automatic test_passthrough();
    logic [NREQ-1:0] g; int n;
    set_op(1, 1'b0, 8'h00, 8'hA5);
    res_ready = 1'b1; req = 4'b0010;
    wait_grant(6, g, n); n_grants++;
    checks++;
    if (g !== 4'b0010) $display("FAIL pass_gnt gnt=%b required 0010", g);
    else passes++;
    tick(); req = '0; tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 8'hA5)
      $display("FAIL pass_result vld=%b id=%0d data=%h required 1 1 a5", res_valid, res_id, res_data);
    else passes++;
    drain();
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] g; int n;
    apply_reset();
    op_a = '0; op_b = '0; op_c = '0;
    res_ready = 1'b1; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(8, g, n); n_grants++;
      checks++;
      if (g !== NREQ'(1 << (k % NREQ))) $display("FAIL fair_order k=%0d gnt=%b required %b", k, g, NREQ'(1 << (k % NREQ)));
      else passes++;
      checks++;
      if (n !== ((k == 0) ? 1 : 4)) $display("FAIL fair_spacing k=%0d gap=%0d required %0d", k, n, (k == 0) ? 1 : 4);
      else passes++;
    end
    drain();
    checks++;
    if (stat_grants !== exp_stats()) $display("FAIL fair_stats stats=%0d required %0d", stat_grants, exp_stats());
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] g; int n;
    apply_reset();
    set_op(3, 1'b1, 8'hFF, 8'h5A);
    res_ready = 1'b0; req = 4'b1000;
    wait_grant(6, g, n); n_grants++;
    tick(); req = 4'b0001; tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd3 || res_data !== 8'h5A)
      $display("FAIL bp_result vld=%b id=%0d data=%h required 1 3 5a", res_valid, res_id, res_data);
    else passes++;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_id !== 2'd3 || res_data !== 8'h5A || gnt !== '0)
        $display("FAIL bp_hold cyc=%0d vld=%b id=%0d data=%h gnt=%b required 1 3 5a 0000", c, res_valid, res_id, res_data, gnt);
      else passes++;
    end
    res_ready = 1'b1;
    tick();
    checks++;
    if (res_valid !== 1'b0) $display("FAIL bp_release vld=%b required 0", res_valid);
    else passes++;
    tick(); n_grants++;
    checks++;
    if (gnt !== 4'b0001) $display("FAIL bp_resume gnt=%b required 0001", gnt);
    else passes++;
    drain();
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] g; int n;
    apply_reset();
    set_op(2, 1'b0, 8'h11, 8'h22);
    res_ready = 1'b1; req = 4'b0100;
    wait_grant(6, g, n);
    tick(); req = '0; rst = 1'b1;
    tick(); rst = 1'b0; m_ptr = 0; n_grants = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || gnt !== '0)
        $display("FAIL rstmid_abort cyc=%0d vld=%b busy=%b gnt=%b required 0 0 0000", c, res_valid, busy, gnt);
      else passes++;
      tick();
    end
    req = 4'b1010;
    wait_grant(6, g, n); n_grants++;
    checks++;
    if (g !== 4'b0010) $display("FAIL rstmid_ptr gnt=%b required 0010", g);
    else passes++;
    drain();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] g, r; int n, w, stall;
    logic [NREQ-1:0] a; logic [NREQ*W-1:0] b, c;
    apply_reset();
    for (int t = 0; t < 25; t++) begin
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      a = NREQ'($urandom); b = {$urandom}; c = {$urandom};
      op_a = a; op_b = b; op_c = c; req = r; res_ready = 1'b0;
      w = rr_pick(r, m_ptr);
      wait_grant(6, g, n);
      checks++;
      if (n !== 1 || g !== NREQ'(1 << w)) $display("FAIL rand_gnt t=%0d lat=%0d gnt=%b required 1 %b", t, n, g, NREQ'(1 << w));
      else passes++;
      m_ptr = (w + 1) % NREQ; n_grants++;
      tick();
      req = '0; op_a = NREQ'($urandom); op_b = {$urandom}; op_c = {$urandom};
      stall = $urandom_range(0, 3);
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_id !== IDW'(w) || res_data !== ref_eval(a[w], b[w*W +: W], c[w*W +: W]))
        $display("FAIL rand_result t=%0d vld=%b id=%0d data=%h required 1 %0d %h", t, res_valid, res_id, res_data, w,
                 ref_eval(a[w], b[w*W +: W], c[w*W +: W]));
      else passes++;
      for (int s = 0; s < stall; s++) begin
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_id !== IDW'(w)) $display("FAIL rand_hold t=%0d vld=%b id=%0d required 1 %0d", t, res_valid, res_id, w);
        else passes++;
      end
      res_ready = 1'b1;
      tick();
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rand_done t=%0d vld=%b busy=%b required 0 0", t, res_valid, busy);
      else passes++;
    end
    checks++;
    if (stat_grants !== exp_stats()) $display("FAIL rand_stats stats=%0d required %0d", stat_grants, exp_stats());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_passthrough();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
